// File: rtl/strait_host_sequencer.sv
// Host-side initiator for a STRAIT instance: runs MBIST, LBIST (SA then TD) and BISR recovery,
// then loads one weight tile and one activation tile, waits for the compute, and streams the result rows out.
module strait_host_sequencer #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = 19,
    parameter int ADDR_WIDTH        = 3,
    parameter int COMPUTE_CYCLES    = 24,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       run,
    output logic                                       row_rd_en,
    output logic                                       row_rd_sel,
    output logic [ADDR_WIDTH-1:0]                      row_rd_addr,
    input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      row_wt_data,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  row_act_data,
    output logic                                       START,
    output logic                                       test_mode,
    output logic                                       BIST_mode,
    output logic                                       weight_valid,
    output logic                                       activation_valid,
    output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      input_weight_flat,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  input_activation_flat,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] input_partial_sum_flat,
    output logic [ADDR_WIDTH-1:0]                      rd_addr,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_outputs_flat,
    input  logic                                       test_done,
    input  logic                                       TD_error_flag,
    input  logic                                       MBIST_FAIL,
    input  logic                                       recovery_success,
    input  logic                                       recovery_done,
    output logic                                       result_valid,
    output logic [ADDR_WIDTH-1:0]                      result_addr,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] result_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       td_err,
    output logic [2:0]                                 err_code
);

    // One shared counter serves the timeouts, the row walks and the compute wait.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + COMPUTE_CYCLES + SYSTOLIC_SIZE + 1);

    localparam logic [CNT_W-1:0] ROWS         = CNT_W'(SYSTOLIC_SIZE);
    localparam logic [CNT_W-1:0] LAST_ROW     = CNT_W'(SYSTOLIC_SIZE - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_MBIST  = 3'd1;
    localparam logic [2:0] ERR_REPAIR = 3'd2;
    localparam logic [2:0] ERR_TO_M   = 3'd3;
    localparam logic [2:0] ERR_TO_L   = 3'd4;
    localparam logic [2:0] ERR_TO_R   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_M_GO, S_M_WAIT, S_L_GO, S_L_WAIT, S_R_WAIT,
        S_LOAD_W, S_LOAD_A, S_COMPUTE, S_READ, S_DONE, S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sa_seen_q, sa_seen_d;
    logic             td_err_q, td_err_d;
    logic [2:0]       err_q, err_d;
    logic             wt_valid_q, act_valid_q, res_valid_q;
    logic [ADDR_WIDTH-1:0] res_addr_q;
    logic             timeout;

    assign timeout = (cnt_q == TIMEOUT_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sa_seen_d   = sa_seen_q;
        td_err_d    = td_err_q;
        err_d       = err_q;
        row_rd_en   = 1'b0;
        row_rd_sel  = 1'b0;
        row_rd_addr = '0;
        START       = 1'b0;
        test_mode   = 1'b0;
        BIST_mode   = 1'b0;
        rd_addr     = '0;
        busy        = 1'b1;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_d = S_M_GO;
            end
            S_M_GO: begin
                START     = 1'b1;
                test_mode = 1'b1;
                state_d   = S_M_WAIT;
            end
            S_M_WAIT: begin
                test_mode = 1'b1;
                if (test_done) begin
                    if (MBIST_FAIL) begin
                        state_d = S_FAIL;
                        err_d   = ERR_MBIST;
                    end else begin
                        state_d = S_L_GO;
                    end
                end else if (timeout) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TO_M;
                end
            end
            S_L_GO: begin
                START     = 1'b1;
                test_mode = 1'b1;
                BIST_mode = 1'b1;
                sa_seen_d = 1'b0;
                state_d   = S_L_WAIT;
            end
            S_L_WAIT: begin
                // test_done wins over a simultaneous recovery_done simply because the latter is not looked at here.
                test_mode = 1'b1;
                BIST_mode = 1'b1;
                if (test_done) begin
                    if (sa_seen_q) begin
                        td_err_d = td_err_q | TD_error_flag;
                        state_d  = S_R_WAIT;
                    end else begin
                        sa_seen_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TO_L;
                end
            end
            S_R_WAIT: begin
                test_mode = 1'b1;
                BIST_mode = 1'b1;
                if (recovery_done) begin
                    if (recovery_success) begin
                        state_d = S_LOAD_W;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = ERR_REPAIR;
                    end
                end else if (timeout) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TO_R;
                end
            end
            S_LOAD_W: begin
                row_rd_en   = 1'b1;
                row_rd_addr = cnt_q[ADDR_WIDTH-1:0];
                if (cnt_q == LAST_ROW) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                row_rd_en   = 1'b1;
                row_rd_sel  = 1'b1;
                row_rd_addr = cnt_q[ADDR_WIDTH-1:0];
                if (cnt_q == LAST_ROW) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (cnt_q == COMPUTE_LAST) state_d = S_READ;
            end
            S_READ: begin
                // One extra cycle after the last address lets row N-1 come back before DONE.
                if (cnt_q < ROWS) rd_addr = cnt_q[ADDR_WIDTH-1:0];
                else              state_d = S_DONE;
            end
            S_DONE, S_FAIL: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (run) begin
                    state_d  = S_M_GO;
                    err_d    = ERR_NONE;
                    td_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sa_seen_q   <= 1'b0;
            td_err_q    <= 1'b0;
            err_q       <= ERR_NONE;
            wt_valid_q  <= 1'b0;
            act_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            sa_seen_q   <= sa_seen_d;
            td_err_q    <= td_err_d;
            err_q       <= err_d;
            wt_valid_q  <= row_rd_en & ~row_rd_sel;
            act_valid_q <= row_rd_en & row_rd_sel;
            res_valid_q <= (state_q == S_READ) && (cnt_q < ROWS);
            res_addr_q  <= rd_addr;
        end
    end

    // Row buffer and accumulator data arrive one cycle after their strobe and pass straight through.
    assign weight_valid           = wt_valid_q;
    assign activation_valid       = act_valid_q;
    assign input_weight_flat      = wt_valid_q  ? row_wt_data  : '0;
    assign input_activation_flat  = act_valid_q ? row_act_data : '0;
    assign input_partial_sum_flat = '0;
    assign result_valid           = res_valid_q;
    assign result_addr            = res_valid_q ? res_addr_q : '0;
    assign result_data            = res_valid_q ? partial_sum_outputs_flat : '0;
    assign td_err                 = td_err_q;
    assign err_code               = err_q;

endmodule

// File: tb/tb_strait_host_sequencer.sv
// Directed bench for strait_host_sequencer: BIST/repair responses are scripted per flow, while a
// row-buffer and accumulator model plus a scoreboard check every tile row and result row.
module tb_strait_host_sequencer;

    localparam int N   = 8;
    localparam int WW  = 8;
    localparam int AW  = 8;
    localparam int PW  = 19;
    localparam int ADW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic row_rd_en, row_rd_sel;
    logic [ADW-1:0]  row_rd_addr;
    logic [N*WW-1:0] row_wt_data  = {N{8'hEE}};
    logic [N*AW-1:0] row_act_data = {N{8'hEE}};
    logic START, test_mode, BIST_mode, weight_valid, activation_valid;
    logic [N*WW-1:0] input_weight_flat;
    logic [N*AW-1:0] input_activation_flat;
    logic [N*PW-1:0] input_partial_sum_flat;
    logic [ADW-1:0]  rd_addr;
    logic [N*PW-1:0] partial_sum_outputs_flat = '0;
    logic test_done = 1'b0, TD_error_flag = 1'b0, MBIST_FAIL = 1'b0;
    logic recovery_success = 1'b0, recovery_done = 1'b0;
    logic result_valid;
    logic [ADW-1:0]  result_addr;
    logic [N*PW-1:0] result_data;
    logic busy, done, td_err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0, av_cnt = 0, rv_cnt = 0, start_cnt = 0;
    logic prev_start = 1'b0;

    logic [N*WW-1:0] wq[$];
    logic [N*AW-1:0] aq[$];
    logic [ADW-1:0]  raq[$];
    logic [N*PW-1:0] rdq[$];

    wire any_out = |{row_rd_en, row_rd_sel, row_rd_addr, START, test_mode, BIST_mode, weight_valid,
                     activation_valid, input_weight_flat, input_activation_flat, input_partial_sum_flat,
                     rd_addr, result_valid, result_addr, result_data, busy, done, td_err, err_code};

    strait_host_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .row_rd_en(row_rd_en), .row_rd_sel(row_rd_sel), .row_rd_addr(row_rd_addr),
        .row_wt_data(row_wt_data), .row_act_data(row_act_data),
        .START(START), .test_mode(test_mode), .BIST_mode(BIST_mode),
        .weight_valid(weight_valid), .activation_valid(activation_valid),
        .input_weight_flat(input_weight_flat), .input_activation_flat(input_activation_flat),
        .input_partial_sum_flat(input_partial_sum_flat), .rd_addr(rd_addr),
        .partial_sum_outputs_flat(partial_sum_outputs_flat),
        .test_done(test_done), .TD_error_flag(TD_error_flag), .MBIST_FAIL(MBIST_FAIL),
        .recovery_success(recovery_success), .recovery_done(recovery_done),
        .result_valid(result_valid), .result_addr(result_addr), .result_data(result_data),
        .busy(busy), .done(done), .td_err(td_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [N*PW-1:0] psum_row(input logic [ADW-1:0] a);
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(int'(a) * 256 + i * 16 + 3);
        return r;
    endfunction

    // Row buffer: weight row r = {8{r}}, activation row r = {8{8'h40|r}}, poison when not read.
    always @(posedge clk) begin
        if (row_rd_en) begin
            row_wt_data  <= {N{{5'b00000, row_rd_addr}}};
            row_act_data <= {N{{5'b01000, row_rd_addr}}};
        end else begin
            row_wt_data  <= {N{8'hEE}};
            row_act_data <= {N{8'hEE}};
        end
        partial_sum_outputs_flat <= psum_row(rd_addr);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (START) begin
            start_cnt++;
            check("start_single_cycle", prev_start, 0);
        end
        prev_start = START;
        if (weight_valid) begin
            wv_cnt++;
            check("wv_av_exclusive", activation_valid, 0);
            if (wq.size() == 0) check("wv_unexpected", weight_valid, 0);
            else                check("weight_row", input_weight_flat, wq.pop_front());
        end
        if (activation_valid) begin
            av_cnt++;
            if (aq.size() == 0) check("av_unexpected", activation_valid, 0);
            else                check("activation_row", input_activation_flat, aq.pop_front());
        end
        if (result_valid) begin
            rv_cnt++;
            if (raq.size() == 0) check("rv_unexpected", result_valid, 0);
            else begin
                check("result_addr", result_addr, raq.pop_front());
                check("result_data", result_data, rdq.pop_front());
            end
        end
    end

    task automatic run_flow(input string name, input bit mbist_fail, input bit td_flag, input bit rec_ok,
                            input bit withhold, input bit mid_run, input bit rst_mid,
                            input logic [2:0] exp_err, input bit exp_done, input bit exp_td,
                            input int exp_starts);
        int lgo_cyc = -1;
        int end_cyc = -1;
        int nstart  = 0;
        logic [2:0] err_hold;
        if (exp_done || rst_mid) begin
            for (int r = 0; r < N; r++) begin
                wq.push_back({N{8'(r)}});
                aq.push_back({N{8'(8'h40 | r)}});
                raq.push_back(ADW'(r));
                rdq.push_back(psum_row(ADW'(r)));
            end
        end
        wv_cnt = 0; av_cnt = 0; rv_cnt = 0; start_cnt = 0;
        @(negedge clk);
        run = 1'b1;
        for (int cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check({name, ":m_go_outputs"}, {START, test_mode, BIST_mode}, 3'b110);
                check({name, ":status_cleared"}, {done, td_err, err_code}, 0);
            end
            if (START) begin
                nstart++;
                if (nstart == 2) lgo_cyc = cyc;
            end
            run              = mid_run && (cyc == 20);
            test_done        = (cyc == 10) || (!withhold && (cyc == 30 || cyc == 50));
            MBIST_FAIL       = mbist_fail && (cyc == 10);
            TD_error_flag    = td_flag && (cyc == 50);
            recovery_done    = (cyc == 60);
            recovery_success = rec_ok && (cyc == 60);
            if (rst_mid && row_rd_en && !row_rd_sel && row_rd_addr == 3) begin
                rst = 1'b1;
                break;
            end
            if (cyc > 1 && !busy) begin
                end_cyc = cyc;
                break;
            end
        end
        run = 1'b0; test_done = 1'b0; MBIST_FAIL = 1'b0; TD_error_flag = 1'b0;
        recovery_done = 1'b0; recovery_success = 1'b0;

        if (rst_mid) begin
            @(negedge clk);
            check({name, ":reset_all_zero"}, any_out, 0);
            check({name, ":weights_left"}, wq.size(), N - 3);
            check({name, ":acts_left"}, aq.size(), N);
            rst = 1'b0;
            wq.delete(); aq.delete(); raq.delete(); rdq.delete();
            return;
        end

        check({name, ":ended"}, end_cyc > 0, 1);
        check({name, ":err_code"}, err_code, exp_err);
        check({name, ":done"}, done, exp_done);
        check({name, ":td_err"}, td_err, exp_td);
        check({name, ":start_pulses"}, nstart, exp_starts);
        check({name, ":weight_pulses"}, wv_cnt, exp_done ? N : 0);
        check({name, ":act_pulses"}, av_cnt, exp_done ? N : 0);
        check({name, ":result_rows"}, rv_cnt, exp_done ? N : 0);
        check({name, ":sb_empty"}, wq.size() + aq.size() + raq.size() + rdq.size(), 0);
        if (withhold) check({name, ":timeout_len"}, end_cyc - lgo_cyc - 1, 4096);

        // Stray events after the flow must change nothing.
        err_hold = err_code;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            test_done     = k[0];
            recovery_done = ~k[0];
            MBIST_FAIL    = 1'b1;
        end
        @(negedge clk);
        test_done = 1'b0; recovery_done = 1'b0; MBIST_FAIL = 1'b0;
        @(negedge clk);
        check({name, ":hold_busy"}, busy, 0);
        check({name, ":hold_done"}, done, exp_done);
        check({name, ":hold_err"}, err_code, err_hold);
        check({name, ":hold_no_start"}, start_cnt, nstart);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_all_zero", any_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_not_busy", busy, 0);

        run_flow("nominal",   0, 0, 1, 0, 1, 0, 3'd0, 1, 0, 2);
        run_flow("mbist",     1, 0, 1, 0, 0, 0, 3'd1, 0, 0, 1);
        run_flow("td_err",    0, 1, 1, 0, 0, 0, 3'd0, 1, 1, 2);
        run_flow("repair",    0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 2);
        run_flow("lbist_tmo", 0, 0, 1, 1, 0, 0, 3'd4, 0, 0, 2);
        run_flow("rst_mid",   0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 0);
        run_flow("restart",   0, 0, 1, 0, 0, 0, 3'd0, 1, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
